// File: rtl/rtc_bus_ctrl.sv
// ============================================================================
//  Module      : rtc_bus_ctrl
//  Description : Runs one multiplexed address/data RTC bus cycle per request
//                and reports completion. Optional macro RTC_SHADOW_REGS_EN
//                adds a 16x8 shadow copy of the bytes that were read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_bus_ctrl #(
    parameter int T_STROBE = 4,
    parameter int T_GAP    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dirout,
    input  logic [3:0] dir_reg,
    input  logic [7:0] dato,
    input  logic       escritura,
    input  logic       lectura,
    input  logic [7:0] ad_in,
    output logic       fin,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       ad_sel,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] dato_leido,
    output logic [3:0] reg_sel,
    output logic       dato_valido
`ifdef RTC_SHADOW_REGS_EN
    ,
    input  logic [3:0] shadow_idx,
    output logic [7:0] shadow_dato
`endif
);

    localparam int c_max_t   = (T_STROBE > T_GAP) ? T_STROBE : T_GAP;
    localparam int c_cnt_w   = $clog2(c_max_t) + 1;
    localparam logic [c_cnt_w-1:0] c_strobe_last = c_cnt_w'(T_STROBE - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last    = c_cnt_w'(T_GAP - 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_addr    = 3'd1;
    localparam logic [2:0] c_st_gap     = 3'd2;
    localparam logic [2:0] c_st_data    = 3'd3;
    localparam logic [2:0] c_st_done    = 3'd4;
    localparam logic [2:0] c_st_recover = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_last;
    logic               w_req;
    logic               w_capture;
    logic [7:0]         r_addr;
    logic [7:0]         r_dato;
    logic [3:0]         r_idx;
    logic               r_is_wr;
    logic [7:0]         r_dato_leido;
    logic [3:0]         r_reg_sel;

    assign w_req     = escritura | lectura;
    // Read data is taken on the edge that leaves DATA, so it is visible in DONE.
    assign w_capture = (r_state == c_st_data) && w_last && !r_is_wr;

    always_comb begin
        w_last = 1'b0;
        case (r_state)
            c_st_addr, c_st_data:   w_last = (r_cnt == c_strobe_last);
            c_st_gap, c_st_recover: w_last = (r_cnt == c_gap_last);
            c_st_done:              w_last = 1'b1;
            default:                w_last = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:    if (w_req)  w_next_state = c_st_addr;
            c_st_addr:    if (w_last) w_next_state = c_st_gap;
            c_st_gap:     if (w_last) w_next_state = c_st_data;
            c_st_data:    if (w_last) w_next_state = c_st_done;
            c_st_done:                w_next_state = c_st_recover;
            c_st_recover: if (w_last) w_next_state = c_st_idle;
            default:                  w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_dato       <= '0;
            r_idx        <= '0;
            r_is_wr      <= 1'b0;
            r_dato_leido <= '0;
            r_reg_sel    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_state != c_st_idle) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == c_st_idle) && w_req) begin
                r_addr  <= dirout;
                r_dato  <= dato;
                r_idx   <= dir_reg;
                r_is_wr <= escritura;
            end
            if (w_capture) begin
                r_dato_leido <= ad_in;
                r_reg_sel    <= r_idx;
            end
        end
    end

    always_comb begin
        fin         = 1'b0;
        dato_valido = 1'b0;
        cs_n        = 1'b1;
        rd_n        = 1'b1;
        wr_n        = 1'b1;
        ad_oe       = 1'b0;
        ad_sel      = 1'b0;
        ad_out      = 8'h00;
        case (r_state)
            c_st_addr: begin
                cs_n   = 1'b0;
                wr_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = r_addr;
            end
            c_st_data: begin
                cs_n   = 1'b0;
                ad_sel = 1'b1;
                if (r_is_wr) begin
                    wr_n   = 1'b0;
                    ad_oe  = 1'b1;
                    ad_out = r_dato;
                end else begin
                    rd_n   = 1'b0;
                end
            end
            c_st_done: begin
                fin         = 1'b1;
                dato_valido = !r_is_wr;
            end
            default: ;
        endcase
    end

    assign dato_leido = r_dato_leido;
    assign reg_sel    = r_reg_sel;

`ifdef RTC_SHADOW_REGS_EN
    logic [7:0] r_shadow [16];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                r_shadow[i] <= 8'h00;
            end
        end else if (w_capture) begin
            r_shadow[r_idx] <= ad_in;
        end
    end

    assign shadow_dato = r_shadow[shadow_idx];
`endif

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_ctrl.sv
// ============================================================================
//  Module      : tb_rtc_bus_ctrl
//  Description : Directed self-checking bench for rtc_bus_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rtc_bus_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dirout;
    logic [3:0] dir_reg;
    logic [7:0] dato;
    logic       escritura;
    logic       lectura;
    logic [7:0] ad_in;
    logic       fin;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       ad_sel;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] dato_leido;
    logic [3:0] reg_sel;
    logic       dato_valido;
`ifdef RTC_SHADOW_REGS_EN
    logic [3:0] shadow_idx = 4'h0;
    logic [7:0] shadow_dato;
`endif

    always #5 clk = ~clk;

    rtc_bus_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .dirout      (dirout),
        .dir_reg     (dir_reg),
        .dato        (dato),
        .escritura   (escritura),
        .lectura     (lectura),
        .ad_in       (ad_in),
        .fin         (fin),
        .ad_out      (ad_out),
        .ad_oe       (ad_oe),
        .ad_sel      (ad_sel),
        .cs_n        (cs_n),
        .rd_n        (rd_n),
        .wr_n        (wr_n),
        .dato_leido  (dato_leido),
        .reg_sel     (reg_sel),
        .dato_valido (dato_valido)
`ifdef RTC_SHADOW_REGS_EN
        ,
        .shadow_idx  (shadow_idx),
        .shadow_dato (shadow_dato)
`endif
    );

    int checks = 0;
    int errors = 0;
    int fin_cnt = 0;
    logic chain_on = 1'b0;

    // {fin, dato_valido, cs_n, rd_n, wr_n, ad_oe, ad_sel, ad_out}
    localparam logic [14:0] c_idle_bus = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    typedef struct {
        logic [7:0] dirout;
        logic [3:0] dir_reg;
        logic [7:0] dato;
        logic       esc;
        logic       lec;
        logic [7:0] ad_in;
        logic       exp_wr;
        logic [7:0] exp_leido;
        logic [3:0] exp_reg;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [14:0] bus_now();
        return {fin, dato_valido, cs_n, rd_n, wr_n, ad_oe, ad_sel, ad_out};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request sampled at edge 0; the expected bus is derived from the phase timeline.
    task automatic run_vec(input vec_t v, input int idx);
        logic [14:0] exp;
        dirout    = v.dirout;
        dir_reg   = v.dir_reg;
        dato      = v.dato;
        escritura = v.esc;
        lectura   = v.lec;
        ad_in     = 8'h5A;
        for (int e = 0; e < 15; e++) begin
            tick();
            if (e <= 3)
                exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, v.dirout};
            else if (e <= 5)
                exp = c_idle_bus;
            else if (e <= 9)
                exp = v.exp_wr ? {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, v.dato}
                               : {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
            else if (e == 10)
                exp = {1'b1, !v.exp_wr, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
            else
                exp = c_idle_bus;
            chk($sformatf("vec%0d_e%0d_bus", idx, e), bus_now(), exp);
            if (e == 10 || e == 14) begin
                chk($sformatf("vec%0d_e%0d_dato_leido", idx, e), dato_leido, v.exp_leido);
                chk($sformatf("vec%0d_e%0d_reg_sel", idx, e), reg_sel, v.exp_reg);
            end
            if (e == 0) begin
                escritura = 1'b0;
                lectura   = 1'b0;
                dirout    = ~v.dirout;
                dato      = ~v.dato;
                dir_reg   = ~v.dir_reg;
            end
            if (e == 10) begin
                escritura = 1'b1;
                lectura   = 1'b1;
            end
            if (e == 13) begin
                escritura = 1'b0;
                lectura   = 1'b0;
            end
            ad_in = (e >= 6 && e <= 9) ? v.ad_in : 8'h5A;
        end
    endtask

    always @(negedge clk) begin
        if (chain_on && fin) fin_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ch_addr [11];
        logic [3:0] ch_reg  [11];
        logic       ch_wr   [11];
        logic [7:0] bus_addr;
        logic       got;

        vecs[0] = '{8'hF0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h11, 1'b1, 8'h00, 4'h0};
        vecs[1] = '{8'h21, 4'h1, 8'hEE, 1'b0, 1'b1, 8'h37, 1'b0, 8'h37, 4'h1};
        vecs[2] = '{8'h8E, 4'h3, 8'h5C, 1'b1, 1'b1, 8'h99, 1'b1, 8'h37, 4'h1};
        vecs[3] = '{8'h43, 4'hB, 8'h12, 1'b0, 1'b1, 8'hC9, 1'b0, 8'hC9, 4'hB};
        vecs[4] = '{8'h00, 4'h7, 8'hFF, 1'b1, 1'b0, 8'h3C, 1'b1, 8'hC9, 4'hB};

        // Reset held with both requests active
        reset = 1'b0; escritura = 1'b1; lectura = 1'b1;
        dirout = 8'hF0; dir_reg = 4'h1; dato = 8'hAA; ad_in = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("reset_c%0d_bus", i), bus_now(), c_idle_bus);
            chk($sformatf("reset_c%0d_leido", i), {dato_leido, reg_sel}, 12'h000);
        end
        reset = 1'b1; escritura = 1'b0; lectura = 1'b0;
        tick();
        chk("post_reset_bus", bus_now(), c_idle_bus);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Reset on the second DATA cycle of a read aborts the cycle
        dirout = 8'h22; dir_reg = 4'h2; lectura = 1'b1; ad_in = 8'h77;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (e == 0) lectura = 1'b0;
        end
        chk("abort_in_data_bus", bus_now(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00});
        reset = 1'b0;
        tick();
        chk("abort_reset_bus", bus_now(), c_idle_bus);
        chk("abort_reset_leido", {dato_leido, reg_sel}, 12'h000);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("abort_after_c%0d_bus", i), bus_now(), c_idle_bus);
        end

        // Sequencer-style chain: write, nine reads, write
        ch_addr = '{8'hF0, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43, 8'hF0};
        ch_reg  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hC, 4'hD, 4'hE, 4'h9, 4'hA, 4'hB, 4'h0};
        ch_wr   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bus_addr = 8'h00;
        chain_on = 1'b1;
        for (int k = 0; k < 11; k++) begin
            dirout = ch_addr[k]; dir_reg = ch_reg[k]; dato = 8'h80;
            escritura = ch_wr[k]; lectura = !ch_wr[k];
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                tick();
                if (ad_oe && !ad_sel && !cs_n) bus_addr = ad_out;
                ad_in = (!cs_n && ad_sel && !rd_n) ? (bus_addr ^ 8'hA5) : 8'h00;
                if (fin) begin
                    got = 1'b1;
                    chk($sformatf("chain%0d_valid", k), dato_valido, !ch_wr[k]);
                    if (!ch_wr[k]) begin
                        chk($sformatf("chain%0d_reg_sel", k), reg_sel, ch_reg[k]);
                        chk($sformatf("chain%0d_leido", k), dato_leido, ch_addr[k] ^ 8'hA5);
`ifdef RTC_SHADOW_REGS_EN
                        shadow_idx = ch_reg[k];
                        #1;
                        chk($sformatf("chain%0d_shadow", k), shadow_dato, ch_addr[k] ^ 8'hA5);
`endif
                    end
                end
            end
            if (!got) chk($sformatf("chain%0d_timeout", k), 32'd0, 32'd1);
            tick();
            escritura = 1'b0;
            lectura   = 1'b0;
        end
        for (int i = 0; i < 4; i++) tick();
        chain_on = 1'b0;
        chk("chain_fin_count", fin_cnt, 11);
`ifdef RTC_SHADOW_REGS_EN
        for (int k = 1; k < 10; k++) begin
            shadow_idx = ch_reg[k];
            #1;
            chk($sformatf("shadow_final%0d", k), shadow_dato, ch_addr[k] ^ 8'hA5);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
